// File: rtl/cosine_sequencer_if.sv
// Handshake and multiplier bus for cosine_sequencer.
// slave = sequencer side, master = angle source / consumer / multiplier side.
interface cosine_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cos;
  logic        out_range_err;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_p;

  modport slave (
    input  in_valid, in_x, out_ready, mul_p,
    output in_ready, out_valid, out_cos, out_range_err, mul_a, mul_b
  );

  modport master (
    output in_valid, in_x, out_ready, mul_p,
    input  in_ready, out_valid, out_cos, out_range_err, mul_a, mul_b
  );
endinterface

// File: rtl/cosine_sequencer.sv
// Q5.11 cos(x) on [0, pi/2] via nested Horner, sharing one external multiplier.
// Optional x^8 term enabled by defining COSINE_SEQ_EXTRA_TERM_EN.
module cosine_sequencer #(
  parameter logic [15:0] X_MAX = 16'h0C91,
  parameter logic [15:0] K2    = 16'h0400,
  parameter logic [15:0] K12   = 16'h00AB,
  parameter logic [15:0] K30   = 16'h0044
) (
  input  logic                clk,
  input  logic                rst_n,
  cosine_sequencer_if.slave   bus
);

  localparam int          DATA_W = 16;
  localparam logic [15:0] ONE    = 16'h0800;
`ifdef COSINE_SEQ_EXTRA_TERM_EN
  localparam logic [15:0] K56    = 16'h0025;
`endif

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_SQ   = 4'd1,
    S_K56  = 4'd2,
    S_K30  = 4'd3,
    S_Q0   = 4'd4,
    S_K12  = 4'd5,
    S_Q1   = 4'd6,
    S_K2   = 4'd7,
    S_Q2   = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [DATA_W-1:0]   prod_q, prod_d;
  logic [DATA_W-1:0]   t_q, t_d;
  logic [DATA_W-1:0]   out_cos_q, out_cos_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   mul_a_c, mul_b_c;

  // 1 - v in Q5.11, floored at zero when truncation pushes v above one
  function automatic logic [DATA_W-1:0] one_minus(input logic [DATA_W-1:0] v);
    return (v > ONE) ? '0 : (ONE - v);
  endfunction

  always_comb begin
    mul_a_c = '0;
    mul_b_c = '0;
    if (rst_n) begin
      unique case (state_q)
        S_SQ:  begin mul_a_c = x_q;    mul_b_c = x_q; end
`ifdef COSINE_SEQ_EXTRA_TERM_EN
        S_K56: begin mul_a_c = y_q;    mul_b_c = K56; end
        S_Q0:  begin mul_a_c = prod_q; mul_b_c = t_q; end
`endif
        S_K30: begin mul_a_c = y_q;    mul_b_c = K30; end
        S_K12: begin mul_a_c = y_q;    mul_b_c = K12; end
        S_Q1:  begin mul_a_c = prod_q; mul_b_c = t_q; end
        S_K2:  begin mul_a_c = y_q;    mul_b_c = K2;  end
        S_Q2:  begin mul_a_c = prod_q; mul_b_c = t_q; end
        default: begin mul_a_c = '0;   mul_b_c = '0;  end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    prod_d      = prod_q;
    t_d         = t_q;
    out_cos_d   = out_cos_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d        = bus.in_x;
          in_ready_d = 1'b0;
          if (bus.in_x > X_MAX) begin
            out_cos_d   = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_SQ;
          end
        end
      end
      S_SQ: begin
        y_d = bus.mul_p;
`ifdef COSINE_SEQ_EXTRA_TERM_EN
        state_d = S_K56;
`else
        state_d = S_K30;
`endif
      end
`ifdef COSINE_SEQ_EXTRA_TERM_EN
      S_K56: begin
        t_d     = one_minus(bus.mul_p);
        state_d = S_K30;
      end
      S_K30: begin
        prod_d  = bus.mul_p;
        state_d = S_Q0;
      end
      S_Q0: begin
        t_d     = one_minus(bus.mul_p);
        state_d = S_K12;
      end
`else
      S_K30: begin
        t_d     = one_minus(bus.mul_p);
        state_d = S_K12;
      end
`endif
      S_K12: begin
        prod_d  = bus.mul_p;
        state_d = S_Q1;
      end
      S_Q1: begin
        t_d     = one_minus(bus.mul_p);
        state_d = S_K2;
      end
      S_K2: begin
        prod_d  = bus.mul_p;
        state_d = S_Q2;
      end
      S_Q2: begin
        out_cos_d   = one_minus(bus.mul_p);
        err_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      prod_q      <= '0;
      t_q         <= '0;
      out_cos_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      prod_q      <= prod_d;
      t_q         <= t_d;
      out_cos_q   <= out_cos_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_cos       = out_cos_q;
  assign bus.out_range_err = err_q;
  assign bus.mul_a         = mul_a_c;
  assign bus.mul_b         = mul_b_c;

endmodule
